tama_cmd_sched: RTL and testbench

- Command scheduler in front of the tamagotchi stats datapath.
- Merges two command sources onto the single 8-bit `inputs` command bus of the stats block:
  - UART receive bytes, queued in a small FIFO.
  - Seven edge-detected push buttons.
- Shapes each granted command as a HOLD pulse followed by a 0x00 GAP, so the stats block sees exactly one action per command and re-arms between commands.
- Arbitrates the two sources round-robin.

---
 rtl/tama_cmd_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_tama_cmd_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tama_cmd_sched.sv
// Command scheduler: merges the UART command FIFO and the edge-detected buttons onto
// the stats `inputs` bus as HOLD/GAP pulses. `define TAMA_WAKE_PRIORITY_EN grants wake first.
module tama_cmd_sched #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    uart_data,
    input  logic                          uart_valid,
    output logic                          uart_ready,
    input  logic [6:0]                    btn,
    output logic [7:0]                    cmd_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    bad_count,
    output logic [7:0]                    drop_count
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = PW + 1;
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_GAP = 2'd2} state_t;

    function automatic logic is_valid_cmd(input logic [7:0] b);
        case (b)
            8'h65, 8'h70, 8'h64, 8'h62, 8'h73, 8'h74, 8'h77: is_valid_cmd = 1'b1;
            default:                                         is_valid_cmd = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] btn_code(input logic [2:0] idx);
        case (idx)
            3'd0:    btn_code = 8'h65;
            3'd1:    btn_code = 8'h70;
            3'd2:    btn_code = 8'h64;
            3'd3:    btn_code = 8'h62;
            3'd4:    btn_code = 8'h73;
            3'd5:    btn_code = 8'h74;
            3'd6:    btn_code = 8'h77;
            default: btn_code = 8'h00;
        endcase
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [7:0]      cmd_r, cmd_s;
    logic            busy_r, rr_r, rr_s;
    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic [6:0]      pend_r, pend_s, btn_prev_r, edge_s, drop_s, clr_s;
    logic [7:0]      bad_r, drop_r, head_s;
    logic [8:0]      drop_sum_s;
    logic [3:0]      drop_n_s;
    logic [2:0]      low_idx_s, sel_idx_s;
    logic            fifo_req_s, btn_req_s, wake_btn_s, wake_fifo_s;
    logic            sel_fifo_s, sel_btn_s, rr_upd_s, pop_s, push_s, bad_s, xfer_s;

    assign head_s     = mem_r[rd_ptr_r];
    assign uart_ready = (level_r != LW'(FIFO_DEPTH));
    assign cmd_out    = cmd_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;
    assign bad_count  = bad_r;
    assign drop_count = drop_r;

    // Source selection: wake override, then round-robin, lowest button index first.
    always_comb begin
        fifo_req_s = (level_r != '0);
        btn_req_s  = |pend_r;
        low_idx_s  = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (pend_r[i]) begin
                low_idx_s = 3'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
`ifdef TAMA_WAKE_PRIORITY_EN
        wake_btn_s  = pend_r[6];
        wake_fifo_s = fifo_req_s && (head_s == 8'h77);
`else
        wake_btn_s  = 1'b0;
        wake_fifo_s = 1'b0;
`endif
        sel_fifo_s = 1'b0;
        sel_btn_s  = 1'b0;
        sel_idx_s  = low_idx_s;
        rr_upd_s   = 1'b1;
        if (wake_btn_s) begin
            sel_btn_s = 1'b1;
            sel_idx_s = 3'd6;
            rr_upd_s  = 1'b0;
        end else if (wake_fifo_s) begin
            sel_fifo_s = 1'b1;
            rr_upd_s   = 1'b0;
        end else if (fifo_req_s && btn_req_s) begin
            sel_fifo_s = !rr_r;
            sel_btn_s  = rr_r;
        end else if (fifo_req_s) begin
            sel_fifo_s = 1'b1;
        end else if (btn_req_s) begin
            sel_btn_s = 1'b1;
        end else begin
            rr_upd_s = 1'b0;
        end
    end

    // FSM next state, pulse-shaping counter and grant side effects.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cmd_s   = cmd_r;
        rr_s    = rr_r;
        pop_s   = 1'b0;
        clr_s   = 7'b0000000;
        case (state_r)
            S_IDLE: begin
                if (sel_fifo_s || sel_btn_s) begin
                    state_s = S_HOLD;
                    cnt_s   = HOLD_LOAD;
                    cmd_s   = sel_fifo_s ? head_s : btn_code(sel_idx_s);
                    pop_s   = sel_fifo_s;
                    if (sel_btn_s) begin
                        clr_s[sel_idx_s] = 1'b1;
                    end else begin
                        clr_s = 7'b0000000;
                    end
                    // rr_ptr=1 hands priority to the buttons on the next contention.
                    if (rr_upd_s) begin
                        rr_s = sel_fifo_s;
                    end else begin
                        rr_s = rr_r;
                    end
                end else begin
                    cmd_s = 8'h00;
                end
            end
            S_HOLD: begin
                if (cnt_r == '0) begin
                    state_s = S_GAP;
                    cnt_s   = GAP_LOAD;
                    cmd_s   = 8'h00;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_r == '0) begin
                    state_s = S_IDLE;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = '0;
                cmd_s   = 8'h00;
            end
        endcase
    end

    // UART acceptance, button edges and drop accounting.
    always_comb begin
        xfer_s   = uart_valid && uart_ready;
        push_s   = xfer_s && is_valid_cmd(uart_data);
        bad_s    = xfer_s && !is_valid_cmd(uart_data);
        edge_s   = btn & ~btn_prev_r;
        drop_s   = edge_s & pend_r & ~clr_s;
        pend_s   = (pend_r & ~clr_s) | edge_s;
        drop_n_s = 4'd0;
        for (int i = 0; i < 7; i++) begin
            drop_n_s = drop_n_s + {3'b000, drop_s[i]};
        end
        drop_sum_s = {1'b0, drop_r} + {5'b00000, drop_n_s};
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            cmd_r      <= 8'h00;
            busy_r     <= 1'b0;
            rr_r       <= 1'b0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            pend_r     <= 7'b0000000;
            btn_prev_r <= 7'b1111111;
            bad_r      <= 8'h00;
            drop_r     <= 8'h00;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            cmd_r      <= cmd_s;
            busy_r     <= (state_s != S_IDLE);
            rr_r       <= rr_s;
            pend_r     <= pend_s;
            btn_prev_r <= btn;
            wr_ptr_r   <= push_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
            rd_ptr_r   <= pop_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            bad_r  <= (bad_s && bad_r != 8'hFF) ? bad_r + 8'h01 : bad_r;
            drop_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= uart_data;
        end
    end
endmodule

// File: tb/tb_tama_cmd_sched.sv
// Randomised and directed bench for tama_cmd_sched; a queue-based reference model
// predicts grants, a monitor pops predictions and checks each HOLD/GAP pulse.
module tb_tama_cmd_sched;
    localparam int DEPTH = 4;
    localparam int H     = 4;
    localparam int G     = 4;
`ifdef TAMA_WAKE_PRIORITY_EN
    localparam bit WAKE = 1'b1;
`else
    localparam bit WAKE = 1'b0;
`endif
    localparam logic [7:0] BTN_CODE [7] = '{8'h65, 8'h70, 8'h64, 8'h62, 8'h73, 8'h74, 8'h77};
    localparam logic [7:0] VALID_SET [7] = '{8'h65, 8'h70, 8'h64, 8'h62, 8'h73, 8'h74, 8'h77};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] uart_data;
    logic       uart_valid;
    logic       uart_ready;
    logic [6:0] btn;
    logic [7:0] cmd_out;
    logic       busy;
    logic [2:0] fifo_level;
    logic [7:0] bad_count;
    logic [7:0] drop_count;

    int n_vec = 0;
    int n_err = 0;

    tama_cmd_sched #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .uart_data(uart_data), .uart_valid(uart_valid),
        .uart_ready(uart_ready), .btn(btn), .cmd_out(cmd_out), .busy(busy),
        .fifo_level(fifo_level), .bad_count(bad_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] fq [$];
    logic [7:0] exp_q [$];
    logic [6:0] m_pend, m_prev;
    int         m_busy_left;
    bit         m_rr;
    int         m_bad, m_drop;

    function automatic bit in_valid_set(input logic [7:0] b);
        for (int i = 0; i < 7; i++) if (VALID_SET[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fq.delete();
            exp_q.delete();
            m_pend = '0; m_prev = 7'h7F; m_busy_left = 0; m_rr = 0; m_bad = 0; m_drop = 0;
        end else begin
            bit accept;
            bit g_fifo;
            int g_btn;
            int lowest;
            accept = uart_valid && (fq.size() != DEPTH);
            g_fifo = 0; g_btn = -1; lowest = -1;
            for (int i = 6; i >= 0; i--) if (m_pend[i]) lowest = i;
            if (m_busy_left == 0) begin
                if (WAKE && m_pend[6]) g_btn = 6;
                else if (WAKE && fq.size() > 0 && fq[0] == 8'h77) g_fifo = 1;
                else if (fq.size() > 0 && (m_pend == 0 || !m_rr)) begin g_fifo = 1; m_rr = 1; end
                else if (m_pend != 0) begin g_btn = lowest; m_rr = 0; end
                if (g_fifo) begin
                    exp_q.push_back(fq.pop_front());
                    m_busy_left = H + G;
                end else if (g_btn >= 0) begin
                    exp_q.push_back(BTN_CODE[g_btn]);
                    m_pend[g_btn] = 1'b0;
                    m_busy_left = H + G;
                end
            end else begin
                m_busy_left--;
            end
            if (accept) begin
                if (in_valid_set(uart_data)) fq.push_back(uart_data);
                else if (m_bad < 255) m_bad++;
            end
            for (int i = 0; i < 7; i++) begin
                if (btn[i] && !m_prev[i]) begin
                    if (m_pend[i]) begin if (m_drop < 255) m_drop++; end
                    else m_pend[i] = 1'b1;
                end
            end
            m_prev = btn;
        end
    end

    // Monitor: pops a prediction at each command start and checks its pulse shape.
    int         act_cnt = 0;
    logic [7:0] cur = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            act_cnt = 0;
        end else begin
            chk("uart_ready", uart_ready, fq.size() != DEPTH);
            chk("fifo_level", fifo_level, fq.size());
            chk("bad_count", bad_count, m_bad);
            chk("drop_count", drop_count, m_drop);
            if (act_cnt == 0) begin
                if (busy) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_cmd: got %0h expected none at %0t", cmd_out, $time);
                        cur = cmd_out;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("cmd_code", cmd_out, cur);
                    end
                    act_cnt = 1;
                end else begin
                    chk("idle_cmd", cmd_out, 8'h00);
                end
            end else begin
                chk("busy_len", busy, 1'b1);
                chk("cmd_shape", cmd_out, (act_cnt < H) ? cur : 8'h00);
                act_cnt++;
                if (act_cnt == H + G) act_cnt = 0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic uart_send(input logic [7:0] b);
        int w;
        w = 0;
        uart_data = b; uart_valid = 1'b1;
        while (!uart_ready && w < 200) begin @(negedge clk); w++; end
        if (w >= 200) begin
            n_vec++; n_err++;
            $display("FAIL uart_timeout: got ready=0 expected ready=1 at %0t", $time);
        end
        @(negedge clk);
        uart_valid = 1'b0;
    endtask

    task automatic press(input int i);
        btn[i] = 1'b1; @(negedge clk);
        btn[i] = 1'b0; @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy || fq.size() != 0 || m_pend != 0 || m_busy_left != 0 || act_cnt != 0)
               && w < 2000) begin
            @(negedge clk); w++;
        end
        if (w >= 2000) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", exp_q.size());
        end
        cycles(2);
    endtask

    initial begin
        reset = 1'b1; btn = 7'h7F; uart_valid = 1'b0; uart_data = 8'h00;
        cycles(3);
        reset = 1'b0;
        #1;
        chk("rst_cmd", cmd_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", uart_ready, 1'b1);
        chk("rst_level", fifo_level, 3'd0);
        // Buttons held through reset release must stay silent.
        cycles(30);
        btn = 7'h00;
        cycles(5);
        // Single UART command.
        uart_send(8'h65);
        drain();
        // Make a button the last winner (rr_ptr=0), then contend FIFO 0x70 vs btn[2].
        press(3); drain();
        btn[2] = 1'b1; uart_send(8'h70); btn[2] = 1'b0;
        drain();
        // Make the FIFO the last winner (rr_ptr=1) and repeat.
        uart_send(8'h62); drain();
        btn[2] = 1'b1; uart_send(8'h70); btn[2] = 1'b0;
        drain();
        // Back-to-back valid bytes while busy: fifth waits for the first pop.
        press(4);
        uart_send(8'h65); uart_send(8'h70); uart_send(8'h64);
        uart_send(8'h62); uart_send(8'h73);
        drain();
        // Rejected byte, then repeated presses of a pending button while busy.
        uart_send(8'h41);
        uart_send(8'h74);
        press(0); press(0); press(0);
        drain();
        // Wake contention: FIFO 0x65 against btn[6] in the same cycle.
        uart_send(8'h62); drain();
        btn[6] = 1'b1; uart_send(8'h65); btn[6] = 1'b0;
        drain();
        btn[6] = 1'b1; uart_send(8'h77); btn[0] = 1'b1; cycles(1); btn = 7'h00;
        drain();
        // Saturation of both counters.
        for (int i = 0; i < 300; i++) uart_send(8'($urandom_range(0, 15)));
        for (int i = 0; i < 500; i++) press(6);
        drain();
        // Randomised mix of UART bytes and button activity.
        for (int c = 0; c < 3000; c++) begin
            uart_valid = ($urandom_range(0, 3) == 0);
            uart_data  = ($urandom_range(0, 3) != 0) ? VALID_SET[$urandom_range(0, 6)]
                                                     : 8'($urandom);
            for (int i = 0; i < 7; i++) if ($urandom_range(0, 19) == 0) btn[i] = ~btn[i];
            @(negedge clk);
        end
        uart_valid = 1'b0; btn = 7'h00;
        drain();
        // Reset in the middle of HOLD aborts the command immediately.
        uart_send(8'h73);
        begin
            int w;
            w = 0;
            while (!(busy && cmd_out != 8'h00) && w < 50) begin @(negedge clk); w++; end
            chk("hold_reached", (busy && cmd_out != 8'h00), 1'b1);
        end
        cycles(1);
        #2 reset = 1'b1;
        #1;
        chk("abort_cmd", cmd_out, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_level", fifo_level, 3'd0);
        cycles(2);
        reset = 1'b0;
        cycles(30);
        chk("exp_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
